// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared limits, hh:mm type and display decode helpers for the RTC core
//   No ports. Provides SEC_MAX/MIN_MAX/HOUR_MAX, hhmm_t, hour_12h() and bin2bcd().
package rtc_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
  } hhmm_t;

  // Returns {pm, display_hour}. Midnight reads as 12 AM and noon as 12 PM.
  function automatic logic [5:0] hour_12h(input logic [4:0] h);
    logic [4:0] d;
    if (h == 5'd0)
      d = 5'd12;
    else if (h > 5'd12)
      d = h - 5'd12;
    else
      d = h;
    return {(h >= 5'd12), d};
  endfunction

  // Two-digit BCD for values 0..59.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtl/rtc_tick_gen.sv - free-running prescaler producing a registered one-cycle 1 Hz tick
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out high for the one cycle in which the prescaler sits at CLK_HZ-1
module rtc_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ);

  logic [CW-1:0] cnt;

  // tick is registered one state early so it coincides with cnt == CLK_HZ-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(CLK_HZ - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(CLK_HZ - 2));
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - hh:mm:ss timekeeper with adjust, 12/24 h display, alarms and hourly chime
//   CP50, nCR              clock, asynchronous active-low reset
//   EN                     count enable for the time-of-day counters
//   Ctrl24To12             0 = 24 h, 1 = 12 h presentation
//   AdjH, AdjM, AlarmSet   hour/minute adjust (edge + auto-repeat), target select
//   AlarmSel, AlarmEn      alarm to set/display, per-alarm enables
//   AlarmStop              silences ringing and clears AlarmHit
//   HourBCD/MinBCD/SecBCD  registered BCD display digits; PM flag
//   Tick1Hz, LEDAlarm, LED0, AlarmHit  tick, ring, chime, sticky hit flags
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter  int CLK_HZ     = 50_000_000,
  parameter  int NUM_ALARMS = 2,
  parameter  int RING_S     = 10,
  parameter  int CHIME_S    = 3,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CP50,
  input  logic                  nCR,
  input  logic                  EN,
  input  logic                  Ctrl24To12,
  input  logic                  AdjH,
  input  logic                  AdjM,
  input  logic                  AlarmSet,
  input  logic [SEL_W-1:0]      AlarmSel,
  input  logic [NUM_ALARMS-1:0] AlarmEn,
  input  logic                  AlarmStop,
  output logic [7:0]            HourBCD,
  output logic [7:0]            MinBCD,
  output logic [7:0]            SecBCD,
  output logic                  PM,
  output logic                  Tick1Hz,
  output logic                  LEDAlarm,
  output logic                  LED0,
  output logic [NUM_ALARMS-1:0] AlarmHit
);

  localparam int RW = $clog2(RING_S + 1);
  localparam int CW = $clog2(CHIME_S + 1);

  rtc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (CP50),
    .rst_n (nCR),
    .tick  (Tick1Hz)
  );

  logic [5:0]            sec_q, sec_n;
  hhmm_t                 tm_q, tm_n;
  hhmm_t                 alm_q [NUM_ALARMS];
  hhmm_t                 alm_n [NUM_ALARMS];
  logic                  adjh_q, adjm_q;
  logic [RW-1:0]         ring_cnt;
  logic [CW-1:0]         chime_cnt;
  logic [7:0]            hour_bcd_q;
  logic                  disp_valid;

  logic                  inc_h, inc_m;
  logic                  sec_carry, min_carry;
  logic [NUM_ALARMS-1:0] match_vec;
  logic                  chime_evt;
  hhmm_t                 sel_alm;
  logic [4:0]            disp_hour;
  logic [5:0]            disp_min, disp_sec;
  logic [5:0]            h12;
  logic [7:0]            hour_bcd_n;
  logic                  pm_n;

  // An edge gives one step; holding the input repeats on each tick. Edge and
  // tick in the same cycle still give a single step.
  assign inc_h = AdjH & (~adjh_q | Tick1Hz);
  assign inc_m = AdjM & (~adjm_q | Tick1Hz);

  always_comb begin
    sec_n     = sec_q;
    tm_n      = tm_q;
    sec_carry = 1'b0;
    min_carry = 1'b0;

    if (Tick1Hz && EN) begin
      if (sec_q == SEC_MAX) begin
        sec_n     = '0;
        sec_carry = 1'b1;
      end else begin
        sec_n = sec_q + 6'd1;
      end
    end

    // An adjusted field swallows any carry arriving in the same cycle and
    // never carries on its own wrap.
    if (inc_m && !AlarmSet) begin
      tm_n.min = (tm_q.min == MIN_MAX) ? '0 : tm_q.min + 6'd1;
    end else if (sec_carry) begin
      if (tm_q.min == MIN_MAX) begin
        tm_n.min  = '0;
        min_carry = 1'b1;
      end else begin
        tm_n.min = tm_q.min + 6'd1;
      end
    end

    if ((inc_h && !AlarmSet) || min_carry)
      tm_n.hour = (tm_q.hour == HOUR_MAX) ? '0 : tm_q.hour + 5'd1;
  end

  always_comb begin
    sel_alm   = '0;
    match_vec = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alm_n[i] = alm_q[i];
      if (AlarmSet && AlarmSel == SEL_W'(i)) begin
        if (inc_m)
          alm_n[i].min = (alm_q[i].min == MIN_MAX) ? '0 : alm_q[i].min + 6'd1;
        if (inc_h)
          alm_n[i].hour = (alm_q[i].hour == HOUR_MAX) ? '0 : alm_q[i].hour + 5'd1;
      end
      if (AlarmSel == SEL_W'(i))
        sel_alm = alm_n[i];
      // Only a tick landing on second 0 can match; adjustment never does.
      match_vec[i] = sec_carry & AlarmEn[i] & (alm_q[i] == tm_n);
    end
    chime_evt = sec_carry && (tm_n.min == 6'd0);
  end

  always_comb begin
    disp_hour  = AlarmSet ? sel_alm.hour : tm_n.hour;
    disp_min   = AlarmSet ? sel_alm.min  : tm_n.min;
    disp_sec   = AlarmSet ? 6'd0         : sec_n;
    h12        = hour_12h(disp_hour);
    hour_bcd_n = Ctrl24To12 ? bin2bcd({1'b0, h12[4:0]}) : bin2bcd({1'b0, disp_hour});
    pm_n       = Ctrl24To12 & h12[5];
  end

  always_ff @(posedge CP50 or negedge nCR) begin
    if (!nCR) begin
      sec_q      <= '0;
      tm_q       <= '0;
      for (int i = 0; i < NUM_ALARMS; i++)
        alm_q[i] <= '0;
      adjh_q     <= 1'b0;
      adjm_q     <= 1'b0;
      ring_cnt   <= '0;
      chime_cnt  <= '0;
      hour_bcd_q <= '0;
      disp_valid <= 1'b0;
      MinBCD     <= '0;
      SecBCD     <= '0;
      PM         <= 1'b0;
      LEDAlarm   <= 1'b0;
      LED0       <= 1'b0;
      AlarmHit   <= '0;
    end else begin
      sec_q      <= sec_n;
      tm_q       <= tm_n;
      alm_q      <= alm_n;
      adjh_q     <= AdjH;
      adjm_q     <= AdjM;
      hour_bcd_q <= hour_bcd_n;
      disp_valid <= 1'b1;
      MinBCD     <= bin2bcd(disp_min);
      SecBCD     <= bin2bcd(disp_sec);
      PM         <= pm_n;

      // Stop outranks a simultaneous match.
      if (AlarmStop) begin
        LEDAlarm <= 1'b0;
        AlarmHit <= '0;
        ring_cnt <= '0;
      end else if (|match_vec) begin
        LEDAlarm <= 1'b1;
        AlarmHit <= AlarmHit | match_vec;
        ring_cnt <= RW'(RING_S);
      end else if (Tick1Hz && ring_cnt != '0) begin
        ring_cnt <= ring_cnt - RW'(1);
        LEDAlarm <= (ring_cnt != RW'(1));
      end

      if (chime_evt) begin
        chime_cnt <= CW'(CHIME_S);
        LED0      <= 1'b1;
      end else if (Tick1Hz && chime_cnt != '0) begin
        chime_cnt <= chime_cnt - CW'(1);
        LED0      <= (chime_cnt != CW'(1));
      end
    end
  end

  // Before the first clock after reset the display register has not loaded,
  // so show the decode of hour 0 directly in whichever mode is selected.
  assign HourBCD = disp_valid ? hour_bcd_q : (Ctrl24To12 ? 8'h12 : 8'h00);

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - directed self-checking bench for rtc_timekeeper
module tb_rtc_timekeeper;

  logic       CP50 = 1'b0;
  logic       nCR = 1'b0;
  logic       EN = 1'b0;
  logic       Ctrl24To12 = 1'b0;
  logic       AdjH = 1'b0;
  logic       AdjM = 1'b0;
  logic       AlarmSet = 1'b0;
  logic [0:0] AlarmSel = 1'b0;
  logic [1:0] AlarmEn = 2'b00;
  logic       AlarmStop = 1'b0;
  logic [7:0] HourBCD, MinBCD, SecBCD;
  logic       PM, Tick1Hz, LEDAlarm, LED0;
  logic [1:0] AlarmHit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CP50 = ~CP50;

  rtc_timekeeper #(.CLK_HZ(4), .NUM_ALARMS(2), .RING_S(10), .CHIME_S(3)) dut (
    .CP50(CP50), .nCR(nCR), .EN(EN), .Ctrl24To12(Ctrl24To12),
    .AdjH(AdjH), .AdjM(AdjM), .AlarmSet(AlarmSet), .AlarmSel(AlarmSel),
    .AlarmEn(AlarmEn), .AlarmStop(AlarmStop),
    .HourBCD(HourBCD), .MinBCD(MinBCD), .SecBCD(SecBCD), .PM(PM),
    .Tick1Hz(Tick1Hz), .LEDAlarm(LEDAlarm), .LED0(LED0), .AlarmHit(AlarmHit)
  );

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CP50);
  endtask

  // Stops at the negedge inside a tick cycle.
  task automatic wait_tick_cycle(input string tag);
    int k;
    k = 0;
    while (Tick1Hz !== 1'b1 && k < 12) begin
      @(negedge CP50);
      k++;
    end
    if (Tick1Hz !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_tick_timeout: Tick1Hz=%b want 1", tag, Tick1Hz);
    end
  endtask

  // Returns at the negedge after the tick, when its effects are visible.
  task automatic wait_tick(input string tag);
    wait_tick_cycle(tag);
    @(negedge CP50);
  endtask

  task automatic do_reset();
    nCR = 1'b0; EN = 1'b0; Ctrl24To12 = 1'b0; AdjH = 1'b0; AdjM = 1'b0;
    AlarmSet = 1'b0; AlarmSel = 1'b0; AlarmEn = 2'b00; AlarmStop = 1'b0;
    step(2);
    nCR = 1'b1;
  endtask

  task automatic pulse_h(input int n);
    repeat (n) begin AdjH = 1'b1; step(1); AdjH = 1'b0; step(1); end
  endtask

  task automatic pulse_m(input int n);
    repeat (n) begin AdjM = 1'b1; step(1); AdjM = 1'b0; step(1); end
  endtask

  task automatic arm_alarm1();
    do_reset();
    AlarmSet = 1'b1; AlarmSel = 1'b1;
    pulse_m(1);
    AlarmSet = 1'b0; AlarmEn = 2'b10; EN = 1'b1;
  endtask

  task automatic test_reset();
    nCR = 1'b0;
    step(2);
    n_cmp++; if (HourBCD !== 8'h00) begin n_bad++; $display("FAIL rst_hour24: got %h want 00", HourBCD); end
    n_cmp++; if (MinBCD !== 8'h00) begin n_bad++; $display("FAIL rst_min: got %h want 00", MinBCD); end
    n_cmp++; if (SecBCD !== 8'h00) begin n_bad++; $display("FAIL rst_sec: got %h want 00", SecBCD); end
    n_cmp++; if ({PM, Tick1Hz, LEDAlarm, LED0, AlarmHit} !== 6'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 000000", {PM, Tick1Hz, LEDAlarm, LED0, AlarmHit}); end
    Ctrl24To12 = 1'b1;
    #1;
    n_cmp++; if (HourBCD !== 8'h12) begin n_bad++; $display("FAIL rst_hour12: got %h want 12", HourBCD); end
    Ctrl24To12 = 1'b0;
    step(1);
    nCR = 1'b1;
    step(2);
    n_cmp++; if (Tick1Hz !== 1'b0) begin n_bad++; $display("FAIL first_tick_early: got %b want 0", Tick1Hz); end
    step(1);
    n_cmp++; if (Tick1Hz !== 1'b1) begin n_bad++; $display("FAIL first_tick: got %b want 1", Tick1Hz); end
  endtask

  task automatic test_count60();
    do_reset();
    EN = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      wait_tick("count");
      n_cmp++; if (SecBCD !== bcd(k % 60)) begin n_bad++; $display("FAIL count_sec%0d: got %h want %h", k, SecBCD, bcd(k % 60)); end
    end
    n_cmp++; if (MinBCD !== 8'h01) begin n_bad++; $display("FAIL count_min: got %h want 01", MinBCD); end
    n_cmp++; if (HourBCD !== 8'h00) begin n_bad++; $display("FAIL count_hour: got %h want 00", HourBCD); end
    n_cmp++; if (LED0 !== 1'b0) begin n_bad++; $display("FAIL count_nochime: got %b want 0", LED0); end
  endtask

  task automatic test_midnight();
    do_reset();
    pulse_h(23);
    pulse_m(59);
    n_cmp++; if ({HourBCD, MinBCD} !== 16'h2359) begin n_bad++; $display("FAIL preload: got %h want 2359", {HourBCD, MinBCD}); end
    EN = 1'b1;
    repeat (59) wait_tick("midnight");
    n_cmp++; if (SecBCD !== 8'h59) begin n_bad++; $display("FAIL preload_sec: got %h want 59", SecBCD); end
    wait_tick("midnight");
    n_cmp++; if ({HourBCD, MinBCD, SecBCD} !== 24'h000000) begin n_bad++; $display("FAIL midnight: got %h want 000000", {HourBCD, MinBCD, SecBCD}); end
    n_cmp++; if (LED0 !== 1'b1) begin n_bad++; $display("FAIL chime_on: got %b want 1", LED0); end
    for (int k = 1; k <= 3; k++) begin
      wait_tick("chime");
      n_cmp++; if (LED0 !== (k < 3)) begin n_bad++; $display("FAIL chime_t%0d: got %b want %b", k, LED0, (k < 3)); end
    end
    Ctrl24To12 = 1'b1;
    step(1);
    n_cmp++; if ({HourBCD, PM} !== {8'h12, 1'b0}) begin n_bad++; $display("FAIL midnight_12h: got %h/%b want 12/0", HourBCD, PM); end
    Ctrl24To12 = 1'b0;
  endtask

  task automatic test_12h();
    do_reset();
    pulse_h(12);
    Ctrl24To12 = 1'b1;
    step(1);
    n_cmp++; if ({HourBCD, PM} !== {8'h12, 1'b1}) begin n_bad++; $display("FAIL noon_12h: got %h/%b want 12/1", HourBCD, PM); end
    pulse_h(1);
    n_cmp++; if ({HourBCD, PM} !== {8'h01, 1'b1}) begin n_bad++; $display("FAIL h13_12h: got %h/%b want 01/1", HourBCD, PM); end
    Ctrl24To12 = 1'b0;
    step(1);
    n_cmp++; if ({HourBCD, PM} !== {8'h13, 1'b0}) begin n_bad++; $display("FAIL h13_24h: got %h/%b want 13/0", HourBCD, PM); end
  endtask

  task automatic test_adjm_hold();
    do_reset();
    pulse_h(5);
    pulse_m(58);
    AdjM = 1'b1;
    step(1);
    n_cmp++; if ({HourBCD, MinBCD} !== 16'h0559) begin n_bad++; $display("FAIL adj_edge: got %h want 0559", {HourBCD, MinBCD}); end
    for (int k = 0; k < 3; k++) begin
      wait_tick("adj_hold");
      n_cmp++; if ({HourBCD, MinBCD} !== {8'h05, bcd(k)}) begin n_bad++; $display("FAIL adj_hold%0d: got %h want %h", k, {HourBCD, MinBCD}, {8'h05, bcd(k)}); end
    end
    AdjM = 1'b0;
    step(1);
  endtask

  task automatic test_adj_carry();
    do_reset();
    pulse_m(10);
    EN = 1'b1;
    repeat (59) wait_tick("adj_carry");
    n_cmp++; if ({MinBCD, SecBCD} !== 16'h1059) begin n_bad++; $display("FAIL carry_pre: got %h want 1059", {MinBCD, SecBCD}); end
    wait_tick_cycle("adj_carry");
    AdjM = 1'b1;
    step(1);
    n_cmp++; if ({HourBCD, MinBCD, SecBCD} !== 24'h001100) begin n_bad++; $display("FAIL carry_adj: got %h want 001100", {HourBCD, MinBCD, SecBCD}); end
    AdjM = 1'b0;
    step(1);
  endtask

  task automatic test_alarm_ring();
    do_reset();
    AlarmSet = 1'b1; AlarmSel = 1'b1;
    pulse_m(1);
    n_cmp++; if ({HourBCD, MinBCD, SecBCD} !== 24'h000100) begin n_bad++; $display("FAIL alarm_disp: got %h want 000100", {HourBCD, MinBCD, SecBCD}); end
    AlarmSel = 1'b0;
    step(1);
    n_cmp++; if (MinBCD !== 8'h00) begin n_bad++; $display("FAIL alarm_sel0: got %h want 00", MinBCD); end
    AlarmSel = 1'b1; AlarmSet = 1'b0; AlarmEn = 2'b10; EN = 1'b1;
    repeat (59) wait_tick("ring");
    n_cmp++; if (LEDAlarm !== 1'b0) begin n_bad++; $display("FAIL ring_early: got %b want 0", LEDAlarm); end
    wait_tick("ring");
    n_cmp++; if ({LEDAlarm, AlarmHit} !== 3'b110) begin n_bad++; $display("FAIL ring_start: got %b want 110", {LEDAlarm, AlarmHit}); end
    for (int k = 1; k <= 10; k++) begin
      wait_tick("ring");
      n_cmp++; if (LEDAlarm !== (k < 10)) begin n_bad++; $display("FAIL ring_t%0d: got %b want %b", k, LEDAlarm, (k < 10)); end
    end
    n_cmp++; if (AlarmHit !== 2'b10) begin n_bad++; $display("FAIL hit_sticky: got %b want 10", AlarmHit); end
  endtask

  task automatic test_alarm_stop();
    int k;
    arm_alarm1();
    repeat (60) wait_tick("stop");
    n_cmp++; if (LEDAlarm !== 1'b1) begin n_bad++; $display("FAIL stop_ring: got %b want 1", LEDAlarm); end
    repeat (2) wait_tick("stop");
    AlarmStop = 1'b1;
    step(1);
    n_cmp++; if ({LEDAlarm, AlarmHit} !== 3'b000) begin n_bad++; $display("FAIL stop_clear: got %b want 000", {LEDAlarm, AlarmHit}); end
    AlarmStop = 1'b0;
    AlarmSet = 1'b1;
    pulse_m(1);
    AlarmSet = 1'b0;
    k = 0;
    while ({MinBCD, SecBCD} !== 16'h0159 && k < 70) begin
      wait_tick("stop");
      k++;
    end
    wait_tick_cycle("stop");
    AlarmStop = 1'b1;
    step(1);
    n_cmp++; if ({MinBCD, SecBCD} !== 16'h0200) begin n_bad++; $display("FAIL stop_match_time: got %h want 0200", {MinBCD, SecBCD}); end
    n_cmp++; if ({LEDAlarm, AlarmHit} !== 3'b000) begin n_bad++; $display("FAIL stop_wins: got %b want 000", {LEDAlarm, AlarmHit}); end
    AlarmStop = 1'b0;
  endtask

  task automatic test_en_hold();
    int ticks;
    do_reset();
    EN = 1'b1;
    repeat (3) wait_tick("en");
    EN = 1'b0;
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      if (Tick1Hz === 1'b1) ticks++;
      step(1);
    end
    n_cmp++; if (ticks != 5) begin n_bad++; $display("FAIL en_ticks: got %0d want 5", ticks); end
    n_cmp++; if ({MinBCD, SecBCD} !== 16'h0003) begin n_bad++; $display("FAIL en_hold: got %h want 0003", {MinBCD, SecBCD}); end
    EN = 1'b1;
    wait_tick("en");
    n_cmp++; if (SecBCD !== 8'h04) begin n_bad++; $display("FAIL en_resume: got %h want 04", SecBCD); end
  endtask

  task automatic test_reset_midring();
    arm_alarm1();
    repeat (63) wait_tick("midring");
    n_cmp++; if (LEDAlarm !== 1'b1) begin n_bad++; $display("FAIL midring_on: got %b want 1", LEDAlarm); end
    #2;
    nCR = 1'b0;
    #1;
    n_cmp++; if ({HourBCD, MinBCD, SecBCD} !== 24'h000000) begin n_bad++; $display("FAIL midring_time: got %h want 000000", {HourBCD, MinBCD, SecBCD}); end
    n_cmp++; if ({PM, Tick1Hz, LEDAlarm, LED0, AlarmHit} !== 6'b0) begin n_bad++; $display("FAIL midring_flags: got %b want 000000", {PM, Tick1Hz, LEDAlarm, LED0, AlarmHit}); end
    @(negedge CP50);
    nCR = 1'b1; EN = 1'b0; AlarmSet = 1'b1; AlarmSel = 1'b1;
    step(1);
    n_cmp++; if (MinBCD !== 8'h00) begin n_bad++; $display("FAIL midring_alarm_clr: got %h want 00", MinBCD); end
    AlarmSet = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count60();
    test_midnight();
    test_12h();
    test_adjm_hold();
    test_adj_carry();
    test_alarm_ring();
    test_alarm_stop();
    test_en_hold();
    test_reset_midring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
